// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR/Cause/EPC/PRId, interrupt/exception
// arbitration, redirect request and eret target. Define CP0_COUNT_EN to add Count/Compare.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0007,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        cp0_we,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] AddrCount   = 5'd9;
  localparam logic [4:0] AddrCompare = 5'd11;
  localparam logic [4:0] AddrSr      = 5'd12;
  localparam logic [4:0] AddrCause   = 5'd13;
  localparam logic [4:0] AddrEpc     = 5'd14;
  localparam logic [4:0] AddrPrid    = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        timer_pend;
  logic [5:0]  ip_next;
  logic        int_req;
  logic        exc_req;
  logic        take;
  logic        wr_en;
  logic [31:0] epc_target;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q, timer_d;

  assign timer_pend = timer_q;
`else
  assign timer_pend = 1'b0;
`endif

  // Request arbitration: interrupts win over synchronous exceptions; EXL masks both.
  assign ip_next    = hw_int | {timer_pend, 5'b0_0000};
  assign int_req    = (|(ip_next & im_q)) & ie_q & ~exl_q;
  assign exc_req    = (exc_code_m != 5'd0) & ~exl_q;
  assign take       = int_req | exc_req;
  assign req        = take & reset_n;
  assign wr_en      = cp0_we & ~take;
  assign epc_target = bd_m ? (pc_m - 32'd4) : pc_m;
  assign handler_pc = HANDLER_ADDR;

  // Forward an in-flight mtc0 EPC so an eret in the same cycle sees the new target.
  always_comb begin
    epc_out = epc_q;
    if (cp0_we && (cp0_addr == AddrEpc)) begin
      epc_out = {cp0_wdata[31:2], 2'b00};
    end
    if (!reset_n) begin
      epc_out = 32'd0;
    end
  end

  assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_word = {cause_bd_q, 15'd0, ip_q | {timer_pend, 5'b0_0000}, 3'd0, exc_code_q, 2'd0};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      AddrSr:      cp0_rdata = sr_word;
      AddrCause:   cp0_rdata = cause_word;
      AddrEpc:     cp0_rdata = epc_q;
      AddrPrid:    cp0_rdata = PRID_VALUE;
`ifdef CP0_COUNT_EN
      AddrCount:   cp0_rdata = count_q;
      AddrCompare: cp0_rdata = compare_q;
`endif
      default:     cp0_rdata = 32'd0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    cause_bd_d = cause_bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = hw_int;

    if (take) begin
      exl_d      = 1'b1;
      cause_bd_d = bd_m;
      exc_code_d = int_req ? 5'd0 : exc_code_m;
      epc_d      = {epc_target[31:2], 2'b00};
    end else begin
      if (eret_m) begin
        exl_d = 1'b0;
      end
      if (wr_en) begin
        case (cp0_addr)
          AddrSr: begin
            im_d  = cp0_wdata[15:10];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
          end
          AddrEpc: epc_d = {cp0_wdata[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_COUNT_EN
  // Timer: pending latches on a Count/Compare match and is only cleared by writing Compare.
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    timer_d   = timer_q | ((count_q == compare_q) && (compare_q != 32'd0));
    if (wr_en && (cp0_addr == AddrCount)) begin
      count_d = cp0_wdata;
    end
    if (wr_en && (cp0_addr == AddrCompare)) begin
      compare_d = cp0_wdata;
      timer_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      cause_bd_q <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      cause_bd_q <= cause_bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: driver pushes reference-model expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_cp0_unit;

  localparam logic [31:0] Prid    = 32'h0000_0007;
  localparam logic [31:0] Handler = 32'h0000_4180;

  logic        clk;
  logic        reset_n;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        cp0_we;
  logic [31:0] cp0_rdata;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  cp0_unit #(
    .PRID_VALUE  (Prid),
    .HANDLER_ADDR(Handler)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .cp0_we    (cp0_we),
    .cp0_rdata (cp0_rdata),
    .pc_m      (pc_m),
    .bd_m      (bd_m),
    .exc_code_m(exc_code_m),
    .eret_m    (eret_m),
    .hw_int    (hw_int),
    .req       (req),
    .handler_pc(handler_pc),
    .epc_out   (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] rdata;
    logic [31:0] epc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Architectural reference state, kept as whole 32-bit register images.
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_tpend;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause | (m_tpend ? 32'h0000_8000 : 32'h0);
      5'd14:   return m_epc;
      5'd15:   return Prid;
`ifdef CP0_COUNT_EN
      5'd9:    return m_count;
      5'd11:   return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic rn, input logic [4:0] a, input logic [31:0] wd,
                       input logic we, input logic [31:0] pc, input logic bd,
                       input logic [4:0] ec, input logic er, input logic [5:0] hw);
    exp_t        e;
    logic [5:0]  ipn;
    logic        intr, excr, rq, wr;
    logic [31:0] tgt;
    logic        match;
    reset_n = rn; cp0_addr = a; cp0_wdata = wd; cp0_we = we; pc_m = pc;
    bd_m = bd; exc_code_m = ec; eret_m = er; hw_int = hw;

    ipn  = hw | (m_tpend ? 6'h20 : 6'h00);
    intr = ((ipn & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    excr = (ec != 5'd0) && !m_sr[1];
    rq   = intr || excr;
    e.req   = rn ? rq : 1'b0;
    e.rdata = m_read(a);
    e.epc   = !rn ? 32'h0 : ((we && a == 5'd14) ? (wd & ~32'h3) : m_epc);
    e.cyc   = cyc_n;
    exp_q.push_back(e);

    if (rn) begin
      wr    = we && !rq;
      match = (m_count == m_compare) && (m_compare != 0);
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      if (rq) begin
        tgt     = bd ? pc - 4 : pc;
        m_sr    = m_sr | 32'h2;
        m_epc   = tgt & ~32'h3;
        m_cause = (bd ? 32'h8000_0000 : 32'h0) | (32'(hw) << 10) |
                  (intr ? 32'h0 : (32'(ec) << 2));
      end else begin
        if (er) m_sr = m_sr & ~32'h2;
        if (wr && a == 5'd12) m_sr = wd & 32'h0000_FC03;
        if (wr && a == 5'd14) m_epc = wd & ~32'h3;
      end
`ifdef CP0_COUNT_EN
      m_tpend   = (wr && a == 5'd11) ? 1'b0 : (m_tpend || match);
      m_count   = (wr && a == 5'd9) ? wd : m_count + 1;
      m_compare = (wr && a == 5'd11) ? wd : m_compare;
`else
      m_tpend = 1'b0 & match;
`endif
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle that only reads a register.
  task automatic rd(input logic [4:0] a, input logic [5:0] hw);
    drive(1'b1, a, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, hw);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want,
                     input int cyc);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req", 32'(req), 32'(e.req), e.cyc);
      chk("cp0_rdata", cp0_rdata, e.rdata, e.cyc);
      chk("epc_out", epc_out, e.epc, e.cyc);
      chk("handler_pc", handler_pc, Handler, e.cyc);
    end
  end

  initial begin
    logic [4:0]  a;
    logic        we, er;
    logic [4:0]  ec;
    logic [5:0]  hw;
    m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tpend = 0;
    reset_n = 1'b0; cp0_addr = 0; cp0_wdata = 0; cp0_we = 0; pc_m = 0; bd_m = 0;
    exc_code_m = 0; eret_m = 0; hw_int = 0;
    @(posedge clk);
    #1;

    // Reset: outputs quiet even with pending stimulus, registers read zero / PRId.
    for (int i = 12; i <= 15; i++) begin
      drive(1'b0, 5'(i), 32'h1234_5677, 1'b1, 32'h100, 1'b1, 5'd4, 1'b0, 6'h3f);
    end

    // Interrupt via hw_int[0] with IM[10]/IE set.
    drive(1'b1, 5'd12, 32'h0000_0401, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'h00);
    drive(1'b1, 5'd13, 32'h0, 1'b0, 32'h3010, 1'b0, 5'd0, 1'b0, 6'h01);
    rd(5'd13, 6'h01);
    rd(5'd14, 6'h01);
    rd(5'd12, 6'h01);
    // eret clears EXL.
    drive(1'b1, 5'd12, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 6'h00);
    rd(5'd12, 6'h00);

    // Reserved-instruction exception in a delay slot with IE = 0.
    drive(1'b1, 5'd12, 32'h0000_0000, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'h00);
    drive(1'b1, 5'd13, 32'h0, 1'b0, 32'h3024, 1'b1, 5'd10, 1'b0, 6'h00);
    rd(5'd13, 6'h00);
    rd(5'd14, 6'h00);

    // eret with same-cycle mtc0 EPC: forwarded, low bits cleared.
    drive(1'b1, 5'd14, 32'h0000_3403, 1'b1, 32'h0, 1'b0, 5'd0, 1'b1, 6'h00);
    rd(5'd14, 6'h00);
    rd(5'd12, 6'h00);

    // Interrupt + exception together; concurrent mtc0 SR discarded.
    drive(1'b1, 5'd12, 32'h0000_0401, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'h00);
    drive(1'b1, 5'd12, 32'h0, 1'b1, 32'h5000, 1'b0, 5'd4, 1'b0, 6'h01);
    rd(5'd12, 6'h00);
    rd(5'd13, 6'h00);
    // Writes to Cause/PRId ignored.
    drive(1'b1, 5'd13, 32'hffff_ffff, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'h00);
    drive(1'b1, 5'd15, 32'hffff_ffff, 1'b1, 32'h0, 1'b0, 5'd0, 1'b1, 6'h00);
    rd(5'd13, 6'h00);

`ifdef CP0_COUNT_EN
    drive(1'b1, 5'd9, 32'h0, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'h00);
    drive(1'b1, 5'd11, 32'h5, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'h00);
    drive(1'b1, 5'd12, 32'h0000_8001, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'h00);
    for (int i = 0; i < 8; i++) rd(5'd13, 6'h00);
    drive(1'b1, 5'd11, 32'h0, 1'b1, 32'h0, 1'b0, 5'd0, 1'b1, 6'h00);
    rd(5'd13, 6'h00);
    rd(5'd9, 6'h00);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0: a = 5'd9;
        1: a = 5'd11;
        2, 3: a = 5'd12;
        4: a = 5'd13;
        5: a = 5'd14;
        6: a = 5'd15;
        default: a = 5'($urandom);
      endcase
      we = ($urandom_range(0, 2) == 0);
      er = ($urandom_range(0, 4) == 0);
      if (er && a == 5'd12) we = 1'b0;
      ec = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      drive(1'b1, a, $urandom, we, $urandom, 1'($urandom), ec, er, hw);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
